// File: rtl/demux32_4_buf_pkg.sv
// Shared constants for the 1-to-4 word distributor: channel count, select width,
// per-channel depth and the occupancy encodings used by every channel FIFO.
package demux32_4_buf_pkg;

  localparam int CH_COUNT   = 4;
  localparam int SEL_W      = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;

  localparam logic [CNT_W-1:0] CNT_EMPTY = 2'd0;
  localparam logic [CNT_W-1:0] CNT_ONE   = 2'd1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  function automatic logic [CH_COUNT-1:0] sel_decode(input logic [SEL_W-1:0] sel);
    sel_decode      = '0;
    sel_decode[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/demux32_4_buf_chan_fifo2.sv
// Two-entry channel FIFO, head registered (push visible next cycle); full count
// is reported upstream so the producer stalls, flush clears all entries to zero.
module chan_fifo2
  import demux32_4_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [CNT_W-1:0] o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  // Unoccupied entries are kept at zero so the head output reads 0 when empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= CNT_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (i_flush) begin
      r_count <= CNT_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_count == CNT_EMPTY) begin
            r_head  <= i_din;
            r_count <= CNT_ONE;
          end else if (r_count == CNT_ONE) begin
            r_tail  <= i_din;
            r_count <= CNT_FULL;
          end
        end
        2'b01: begin
          if (r_count == CNT_FULL) begin
            r_head  <= r_tail;
            r_tail  <= '0;
            r_count <= CNT_ONE;
          end else if (r_count == CNT_ONE) begin
            r_head  <= '0;
            r_count <= CNT_EMPTY;
          end
        end
        2'b11: begin
          if (r_count == CNT_EMPTY) begin
            r_head  <= i_din;
            r_count <= CNT_ONE;
          end else if (r_count == CNT_ONE) begin
            r_head <= i_din;
          end else begin
            r_head  <= r_tail;
            r_tail  <= '0;
            r_count <= CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_head;

endmodule

// File: rtl/demux32_4_buf.sv
// Buffered 1-to-4 word distributor, 1-cycle latency into a per-channel 2-deep FIFO;
// in_ready drops only when the selected channel is full or during flush/reset.
module demux32_4_buf
  import demux32_4_buf_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    in_select,
  input  logic [WIDTH-1:0]    in_data,
  output logic [CH_COUNT-1:0] out_valid,
  input  logic [CH_COUNT-1:0] out_ready,
  output logic [WIDTH-1:0]    out0_data,
  output logic [WIDTH-1:0]    out1_data,
  output logic [WIDTH-1:0]    out2_data,
  output logic [WIDTH-1:0]    out3_data
);

  logic [CNT_W-1:0]    w_count [CH_COUNT];
  logic [WIDTH-1:0]    w_head  [CH_COUNT];
  logic [CH_COUNT-1:0] w_push;
  logic [CH_COUNT-1:0] w_pop;

  // Depends only on registered counts and the select, never on out_ready.
  assign in_ready = reset_n & ~flush & (w_count[in_select] != CNT_FULL);
  assign w_push   = (in_valid & in_ready) ? sel_decode(in_select) : '0;
  assign w_pop    = out_valid & out_ready;

  for (genvar g = 0; g < CH_COUNT; g++) begin : g_ch
    chan_fifo2 #(
      .WIDTH(WIDTH)
    ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .i_flush (flush),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_din   (in_data),
      .o_count (w_count[g]),
      .o_head  (w_head[g])
    );
    assign out_valid[g] = (w_count[g] != CNT_EMPTY);
  end

  assign out0_data = w_head[0];
  assign out1_data = w_head[1];
  assign out2_data = w_head[2];
  assign out3_data = w_head[3];

endmodule

// File: tb/tb_demux32_4_buf.sv
// Randomised and directed bench for demux32_4_buf: per-channel expected-word queues
// filled at push time, drained by a monitor that compares every channel each cycle.
module tb_demux32_4_buf;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_select;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out0_data;
  logic [31:0] out1_data;
  logic [31:0] out2_data;
  logic [31:0] out3_data;

  demux32_4_buf #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_select (in_select),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out3_data (out3_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] q [4][$];
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] head_of(input int ch);
    case (ch)
      0:       head_of = out0_data;
      1:       head_of = out1_data;
      2:       head_of = out2_data;
      default: head_of = out3_data;
    endcase
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 4; c++) q[c].delete();
  endtask

  // Monitor: outputs are stable mid-cycle; pops take effect at the next rising edge.
  always @(negedge clock) begin
    logic exp_rdy;
    exp_rdy = reset_n && !flush && (q[in_select].size() < 2);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("out_valid[%0d]", c), {31'b0, out_valid[c]}, {31'b0, q[c].size() != 0});
      if (q[c].size() != 0) begin
        chk($sformatf("out%0d_data", c), head_of(c), q[c][0]);
        if (out_ready[c] && !flush && reset_n) void'(q[c].pop_front());
      end else begin
        chk($sformatf("out%0d_data_empty", c), head_of(c), 32'h0);
      end
    end
  end

  // One clock of stimulus; the model accepts by the specification's rule, not by in_ready.
  task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                      input logic [3:0] r, input logic f, output logic acc);
    in_valid  = v;
    in_select = s;
    in_data   = d;
    out_ready = r;
    flush     = f;
    acc = v && !f && reset_n && (q[s].size() < 2);
    @(posedge clock);
    if (f) clear_model();
    else if (acc) q[s].push_back(d);
    #1;
  endtask

  task automatic idle(input logic [3:0] r, input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'h0, r, 1'b0, a);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    clear_model();
    repeat (cycles) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic acc;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_select = 2'd0;
    in_data   = 32'h0;
    out_ready = 4'h0;
    do_reset(3);

    // Single route to channel 2.
    step(1'b1, 2'd2, 32'hDEADBEEF, 4'h0, 1'b0, acc);
    idle(4'h0, 2);
    idle(4'hF, 2);

    // Backpressure on channel 1: A3 must wait until A1 leaves.
    step(1'b1, 2'd1, 32'hA1, 4'h0, 1'b0, acc);
    step(1'b1, 2'd1, 32'hA2, 4'h0, 1'b0, acc);
    for (int i = 0; i < 4; i++) step(1'b1, 2'd1, 32'hA3, 4'h0, 1'b0, acc);
    acc = 1'b0;
    for (int i = 0; i < 6 && !acc; i++) step(1'b1, 2'd1, 32'hA3, 4'b0010, 1'b0, acc);
    idle(4'b0010, 4);

    // Channel 0 stalled full while channel 3 streams at one word per cycle.
    step(1'b1, 2'd0, 32'hC0, 4'h0, 1'b0, acc);
    step(1'b1, 2'd0, 32'hC1, 4'h0, 1'b0, acc);
    for (int i = 0; i < 8; i++) step(1'b1, 2'd3, 32'h3000_0000 + i, 4'b1000, 1'b0, acc);
    idle(4'b1000, 3);
    idle(4'b0001, 3);

    // Push and pop together at count 1 on channel 0.
    step(1'b1, 2'd0, 32'hB1, 4'h0, 1'b0, acc);
    step(1'b1, 2'd0, 32'hB2, 4'b0001, 1'b0, acc);
    idle(4'h0, 2);
    idle(4'hF, 2);

    // Flush with a word offered and counts {1,2,0,1}.
    step(1'b1, 2'd0, 32'hF0, 4'h0, 1'b0, acc);
    step(1'b1, 2'd1, 32'hF1, 4'h0, 1'b0, acc);
    step(1'b1, 2'd1, 32'hF2, 4'h0, 1'b0, acc);
    step(1'b1, 2'd3, 32'hF3, 4'h0, 1'b0, acc);
    step(1'b1, 2'd2, 32'hF4, 4'hF, 1'b1, acc);
    idle(4'h0, 2);

    // Asynchronous reset mid-stream with counts {2,1,0,2} and a word in flight.
    step(1'b1, 2'd0, 32'hE0, 4'h0, 1'b0, acc);
    step(1'b1, 2'd0, 32'hE1, 4'h0, 1'b0, acc);
    step(1'b1, 2'd1, 32'hE2, 4'h0, 1'b0, acc);
    step(1'b1, 2'd3, 32'hE3, 4'h0, 1'b0, acc);
    step(1'b1, 2'd3, 32'hE4, 4'h0, 1'b0, acc);
    in_valid  = 1'b1;
    in_select = 2'd2;
    in_data   = 32'hE5;
    do_reset(2);
    in_valid = 1'b0;
    idle(4'h0, 2);

    // Random traffic with mixed consumer stalls and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 59) == 0), acc);
    end
    idle(4'hF, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
